serial_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, rippling the carry through a registered carry flop between chunks. It succeeds the single-bit combinational full adder as the team's general-purpose arithmetic block. It trades latency for a short critical path of CHUNK full-adder cells. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_chunk_adder_pkg.sv | 37 +++
 rtl/serial_chunk_adder_fa_chunk.sv | 41 ++++
 rtl/serial_chunk_adder.sv | 129 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_chunk_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_chunk_adder_pkg
// Purpose  : Shared definitions for the serial chunk adder: FSM state
//            encoding, operation codes and helpers that derive the chunk
//            count and chunk-index width from WIDTH and CHUNK.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of CHUNK-bit slices making up a WIDTH-bit operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index counter width; kept at least 1 bit so WIDTH == CHUNK still
  // yields a legal vector.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_chunk_adder_fa_chunk.sv
//------------------------------------------------------------------------------
// Module   : fa_chunk
// Purpose  : Purely combinational CHUNK-bit ripple of full-adder cells.
// Ports    : x, y  - CHUNK-bit addends
//            ci    - carry into bit 0
//            s     - CHUNK-bit sum
//            co    - carry out of the top bit
//            c_msb - carry into the top bit (for signed overflow)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  always_comb begin
    logic w_carry;
    w_carry = ci;
    c_msb   = ci;
    s       = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        c_msb = w_carry;
      end
      s[i]    = x[i] ^ y[i] ^ w_carry;
      w_carry = (x[i] & y[i]) | (x[i] & w_carry) | (y[i] & w_carry);
    end
    co = w_carry;
  end

endmodule

`default_nettype wire

// File: rtl/serial_chunk_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_chunk_adder
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per
//            clock, LSB chunk first, with the inter-chunk carry held in a
//            register. Valid/ready handshakes on both sides.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_valid/in_ready - operand handshake
//            op                - 0 add, 1 subtract (a - b)
//            a, b, cin         - operands and carry-in (cin ignored for sub)
//            out_valid/out_ready - result handshake
//            sum, cout, ovf    - result, carry out, signed overflow
//            busy              - operation in flight or result pending
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(WIDTH, CHUNK);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_DONE = ST_DONE;

  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NCHUNK - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_cout;
  logic             r_ovf;

  int unsigned      w_base;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_c_msb;
  logic             w_sub;

  assign w_base = int'(r_idx) * CHUNK;
  assign w_sub  = (op == OP_SUB);

  fa_chunk #(
    .CHUNK (CHUNK)
  ) u_fa_chunk (
    .x     (r_a[w_base +: CHUNK]),
    .y     (r_b[w_base +: CHUNK]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_sum[w_base +: CHUNK] <= w_s;
          r_carry                <= w_co;
          if (r_idx == c_last_idx) begin
            r_cout  <= w_co;
            r_ovf   <= w_c_msb ^ w_co;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_chunk_adder
// Purpose  : Directed self-checking bench for serial_chunk_adder at default
//            parameters, with a queue of expected results.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_chunk_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_chunk_adder #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one operation and hold in_valid through the accept edge.
  task automatic send(input logic o, input logic [15:0] x, input logic [15:0] y,
                      input logic c, input logic [15:0] es, input logic ec,
                      input logic eo);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo;
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    op = o; a = x; b = y; cin = c; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), verify latency and the queued result.
  task automatic collect(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    if (sb.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"},  {16'd0, sum}, {16'd0, e.sum});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e.cout});
      chk({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e.ovf});
    end
  endtask

  // Complete the output handshake in one cycle.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_cleared"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready_back"},     {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
    out_ready = 1'b0;

    // Reset held 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_sum",       {16'd0, sum},       32'h0000);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Plain add.
    send(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    collect("add_basic", 4);
    drain("add_basic");

    // Full carry ripple through every chunk.
    send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    collect("add_ripple", 4);
    drain("add_ripple");

    // Carry-in producing positive overflow.
    send(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    collect("add_ovf", 4);
    drain("add_ovf");

    // Subtract with overflow; cin must be ignored.
    send(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    collect("sub_ovf", 4);
    drain("sub_ovf");

    // Subtract with borrow.
    send(1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    collect("sub_borrow", 4);
    drain("sub_borrow");

    // Backpressure: result held while new operands are offered.
    send(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    collect("bp_first", 4);
    op = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_low",   {31'd0, in_ready},  32'd0);
      chk("bp_sum_frozen",     {16'd0, sum},       32'h3333);
    end
    begin
      exp_t e;
      e.sum = 16'hFFFE; e.cout = 1'b1; e.ovf = 1'b0;
      sb.push_back(e);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_busy",     {31'd0, busy},     32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accept_busy", {31'd0, busy}, 32'd1);
    collect("bp_second", 4);
    drain("bp_second");

    // Reset pulsed during the second BUSY cycle.
    @(negedge clk);
    op = 1'b0; a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_sum",       {16'd0, sum},       32'h0000);
    chk("midrst_busy",      {31'd0, busy},      32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_out_valid", {31'd0, seen}, 32'd0);
    send(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    collect("after_rst", 4);
    drain("after_rst");

    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
